// File: rtl/mode_scheduler_pkg.sv
// Shared definitions for the TRAIN/TEST mode scheduler: mode encodings seen by
// the network layers and the scheduler state encoding.
package mode_scheduler_pkg;

  // Mode encodings driven to the input layer (shared with downstream layers)
  localparam logic MODE_TRAIN = 1'b1;
  localparam logic MODE_TEST  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PH_TRAIN = 3'd1,
    ST_DR_TRAIN = 3'd2,
    ST_PH_TEST  = 3'd3,
    ST_DR_TEST  = 3'd4,
    ST_END_EP   = 3'd5,
    ST_DONE     = 3'd6
  } sched_state_t;

  // An epoch starts with training unless there are no training samples
  function automatic sched_state_t first_phase(input logic train_zero);
    return train_zero ? ST_PH_TEST : ST_PH_TRAIN;
  endfunction

endpackage

// File: rtl/mode_scheduler_if.sv
// Signal bundle between the sample source / network and the mode scheduler.
// Optional oStall counter output exists only when MODE_SCHED_STATS_EN is defined.
interface mode_scheduler_if #(
  parameter int NC = 7,
  parameter int WF = 5,
  parameter int WS = 16,
  parameter int WE = 8
);
  logic              iStart;
  logic [WS-1:0]     iNumTrain;
  logic [WS-1:0]     iNumTest;
  logic [WE-1:0]     iNumEpoch;
  logic              iValid_AM_Sample;
  logic              oReady_AM_Sample;
  logic [NC*WF-1:0]  iData_AM_Sample;
  logic              oValid_BM_Sample;
  logic              iReady_BM_Sample;
  logic [NC*WF-1:0]  oData_BM_Sample;
  logic              iValid_AS_Done;
  logic              oReady_AS_Done;
  logic              oMode;
  logic [WE-1:0]     oEpoch;
  logic              oBusy;
  logic              oDone;
`ifdef MODE_SCHED_STATS_EN
  logic [31:0]       oStall;

  modport master (
    output iStart, iNumTrain, iNumTest, iNumEpoch,
    output iValid_AM_Sample, iData_AM_Sample, iReady_BM_Sample, iValid_AS_Done,
    input  oReady_AM_Sample, oValid_BM_Sample, oData_BM_Sample, oReady_AS_Done,
    input  oMode, oEpoch, oBusy, oDone, oStall
  );

  modport slave (
    input  iStart, iNumTrain, iNumTest, iNumEpoch,
    input  iValid_AM_Sample, iData_AM_Sample, iReady_BM_Sample, iValid_AS_Done,
    output oReady_AM_Sample, oValid_BM_Sample, oData_BM_Sample, oReady_AS_Done,
    output oMode, oEpoch, oBusy, oDone, oStall
  );
`else
  modport master (
    output iStart, iNumTrain, iNumTest, iNumEpoch,
    output iValid_AM_Sample, iData_AM_Sample, iReady_BM_Sample, iValid_AS_Done,
    input  oReady_AM_Sample, oValid_BM_Sample, oData_BM_Sample, oReady_AS_Done,
    input  oMode, oEpoch, oBusy, oDone
  );

  modport slave (
    input  iStart, iNumTrain, iNumTest, iNumEpoch,
    input  iValid_AM_Sample, iData_AM_Sample, iReady_BM_Sample, iValid_AS_Done,
    output oReady_AM_Sample, oValid_BM_Sample, oData_BM_Sample, oReady_AS_Done,
    output oMode, oEpoch, oBusy, oDone
  );
`endif
endinterface

// File: rtl/mode_scheduler_flight_counter.sv
// Up/down counter of samples between the input layer and the network tail.
// A decrement at zero is dropped; an increment at MAX is dropped.
module mode_scheduler_flight_counter #(
  parameter int WI  = 3,
  parameter int MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [WI-1:0] count,
  output logic          full,
  output logic          empty
);

  logic inc_ok;
  logic dec_ok;

  assign inc_ok = inc && (count != WI'(MAX));
  assign dec_ok = dec && (count != '0);
  assign full   = (count == WI'(MAX));
  assign empty  = (count == '0);

  // Net change per cycle; simultaneous valid inc and dec cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + WI'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - WI'(1);
    end
  end

endmodule

// File: rtl/mode_scheduler.sv
// TRAIN/TEST phase sequencer: gates the sample stream into the input layer,
// tracks samples in flight, and only changes mode once the pipeline is empty.
// Optional build macro: MODE_SCHED_STATS_EN adds the oStall stall-cycle counter.
//
// state     | meaning
// IDLE      | waiting for iStart
// PH_TRAIN  | issuing training samples (oMode=TRAIN)
// DR_TRAIN  | training issue complete, draining in-flight samples
// PH_TEST   | issuing test samples (oMode=TEST)
// DR_TEST   | test issue complete, draining in-flight samples
// END_EP    | one-cycle epoch bookkeeping
// DONE      | one-cycle oDone pulse; iStart honoured here too
module mode_scheduler
  import mode_scheduler_pkg::*;
#(
  parameter int NC        = 7,
  parameter int WF        = 5,
  parameter int WS        = 16,
  parameter int WE        = 8,
  parameter int MAXFLIGHT = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  mode_scheduler_if.slave    bus
);

  localparam int WI = $clog2(MAXFLIGHT + 1);
  localparam int WD = NC * WF;

  sched_state_t  state;
  sched_state_t  state_nx;
  logic [WS-1:0] num_train;
  logic [WS-1:0] num_test;
  logic [WE-1:0] num_epoch;
  logic [WE-1:0] epoch;
  logic [WS-1:0] issued;
  logic [WS-1:0] target;
  logic [WI-1:0] inflight;
  logic [WD-1:0] data;
  logic          full;
  logic          empty;
  logic          in_phase;
  logic          gate;
  logic          issue;
  logic          retire;
  logic          busy;
  logic          ready_done;
  logic          latch_cfg;
  logic          epoch_inc;

  assign in_phase = (state == ST_PH_TRAIN) || (state == ST_PH_TEST);
  assign target   = (state == ST_PH_TRAIN) ? num_train : num_test;
  assign gate     = in_phase && (issued < target) && !full;

  assign data                 = bus.iData_AM_Sample;
  assign bus.oData_BM_Sample  = data;
  assign bus.oValid_BM_Sample = bus.iValid_AM_Sample & gate;
  assign bus.oReady_AM_Sample = bus.iReady_BM_Sample & gate;
  assign issue                = bus.iValid_AM_Sample & bus.iReady_BM_Sample & gate;
  assign retire               = bus.iValid_AS_Done;

  assign busy               = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.oBusy          = busy;
  assign bus.oDone          = (state == ST_DONE);
  assign bus.oMode          = ((state == ST_PH_TRAIN) || (state == ST_DR_TRAIN)) ? MODE_TRAIN : MODE_TEST;
  assign bus.oEpoch         = epoch;
  assign bus.oReady_AS_Done = ready_done;

  mode_scheduler_flight_counter #(
    .WI  (WI),
    .MAX (MAXFLIGHT)
  ) u_flight (
    .clk   (iCLK),
    .rst   (iRST),
    .inc   (issue),
    .dec   (retire),
    .count (inflight),
    .full  (full),
    .empty (empty)
  );

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and config/epoch strobes
  always_comb begin
    state_nx  = state;
    latch_cfg = 1'b0;
    epoch_inc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.iStart) begin
          latch_cfg = 1'b1;
          if ((bus.iNumEpoch == '0) || ((bus.iNumTrain == '0) && (bus.iNumTest == '0))) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = first_phase(bus.iNumTrain == '0);
          end
        end else if (state == ST_DONE) begin
          state_nx = ST_IDLE;
        end
      end
      ST_PH_TRAIN: begin
        if (issued == num_train) state_nx = ST_DR_TRAIN;
      end
      ST_DR_TRAIN: begin
        if (empty) state_nx = (num_test == '0) ? ST_END_EP : ST_PH_TEST;
      end
      ST_PH_TEST: begin
        if (issued == num_test) state_nx = ST_DR_TEST;
      end
      ST_DR_TEST: begin
        if (empty) state_nx = ST_END_EP;
      end
      ST_END_EP: begin
        if (WE'(epoch + WE'(1)) == num_epoch) begin
          state_nx = ST_DONE;
        end else begin
          epoch_inc = 1'b1;
          state_nx  = first_phase(num_train == '0);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Run configuration captured when a start is accepted
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      num_train <= '0;
      num_test  <= '0;
      num_epoch <= '0;
    end else if (latch_cfg) begin
      num_train <= bus.iNumTrain;
      num_test  <= bus.iNumTest;
      num_epoch <= bus.iNumEpoch;
    end
  end

  // Epoch index: cleared on start, advanced at each non-final epoch end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      epoch <= '0;
    end else if (latch_cfg) begin
      epoch <= '0;
    end else if (epoch_inc) begin
      epoch <= epoch + WE'(1);
    end
  end

  // Per-phase issue count; held at zero outside the issuing phases so every phase starts fresh
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      issued <= '0;
    end else if (!in_phase) begin
      issued <= '0;
    end else if (issue) begin
      issued <= issued + WS'(1);
    end
  end

  // Completion channel is always ready once out of reset
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ready_done <= 1'b0;
    end else begin
      ready_done <= 1'b1;
    end
  end

`ifdef MODE_SCHED_STATS_EN
  logic [31:0] stall;

  // Cycles where the source is held off during a run, saturating
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stall <= '0;
    end else if (latch_cfg) begin
      stall <= '0;
    end else if (busy && bus.iValid_AM_Sample && !bus.oReady_AM_Sample && (stall != '1)) begin
      stall <= stall + 32'd1;
    end
  end

  assign bus.oStall = stall;
`endif

endmodule
